fifod2mac: RTL and testbench

//  Transmit-side bridge from the device data FIFO into the MAC UDP transmit buffer.
//  On fs it pulls dev_tx_len bytes from the FIFO and writes them to consecutive buffer addresses from 0.
//  It then requests a UDP send with length payload+8 and raises fd once the MAC confirms.

---
 rtl/fifod2mac.sv | 146 ++++++++++++++
 tb/tb_fifod2mac.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifod2mac.sv
// Purpose : moves one frame of dev_tx_len bytes (clamped to MAX_LEN) from the device
//           FIFO into the MAC UDP TX buffer at addresses 0.., then requests a UDP send.
// Latency : FIFO read to buffer write 1 cycle; SEND entered the cycle after the last write.
// Backpressure: an empty FIFO stalls reads indefinitely; WAIT holds until udp_tx_done,
//           and LAST holds fd high until fs drops.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   fs / fd             frame start level in, frame done level out (high in LAST)
//   dev_tx_len          payload byte count, sampled in IDLE when fs=1
//   fifo_rxd/empty/rxen FIFO read port (non fall-through, data 1 cycle after rxen)
//   udp_txd/addr/wen    TX buffer write port
//   udp_tx_len/req/done UDP send handshake (len = payload+8, req 1-cycle pulse)
//
// Build option: define FIFOD2MAC_PAD_EN to zero-pad short payloads up to MIN_LEN bytes.
module fifod2mac #(
    parameter int ADDR_W  = 11,
    parameter int LEN_W   = 12,
    parameter int MAX_LEN = 1472,
    parameter int MIN_LEN = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs,
    output logic              fd,
    input  logic [LEN_W-1:0]  dev_tx_len,
    input  logic [7:0]        fifo_rxd,
    input  logic              fifo_empty,
    output logic              fifo_rxen,
    output logic [7:0]        udp_txd,
    output logic [ADDR_W-1:0] udp_tx_addr,
    output logic              udp_tx_wen,
    output logic [15:0]       udp_tx_len,
    output logic              udp_tx_req,
    input  logic              udp_tx_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        LAST = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t            state;
    logic [LEN_W-1:0]  len_reg;   // clamped payload length of the current frame
    logic [LEN_W-1:0]  rd_cnt;    // FIFO reads issued
    logic [LEN_W-1:0]  wr_cnt;    // buffer writes issued (data + padding)
    logic [LEN_W-1:0]  eff_len;   // total bytes written to the buffer
    logic              pad_wr;    // current buffer write is a padding byte
    logic              pad_go;

`ifdef FIFOD2MAC_PAD_EN
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    assign eff_len = (len_reg < MIN_L) ? MIN_L : len_reg;
`else
    assign eff_len = len_reg;
`endif

    // The read enable has to react to fifo_empty in the same cycle; a registered
    // enable would issue one read past the last byte of a nearly-empty FIFO.
    assign fifo_rxen = (state == READ) && !fifo_empty && (rd_cnt < len_reg);

    // Padding starts once every FIFO read has been issued; it never touches the FIFO.
    // Without padding eff_len == len_reg == rd_cnt here, so this stays low.
    assign pad_go = (state == READ) && (rd_cnt == len_reg) && (wr_cnt < eff_len);

    // FIFO data arrives in the cycle the delayed write enable is high, so the write
    // data is taken straight from the FIFO output; zero whenever no data write is active.
    assign udp_txd = (udp_tx_wen && !pad_wr) ? fifo_rxd : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_reg     <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            pad_wr      <= 1'b0;
            fd          <= 1'b0;
            udp_tx_addr <= '0;
            udp_tx_wen  <= 1'b0;
            udp_tx_len  <= '0;
            udp_tx_req  <= 1'b0;
        end else begin
            udp_tx_wen <= 1'b0;
            udp_tx_req <= 1'b0;
            pad_wr     <= 1'b0;
            case (state)
                IDLE: begin
                    if (fs) begin
                        if (dev_tx_len != '0) begin
                            len_reg <= (dev_tx_len > MAX_L) ? MAX_L : dev_tx_len;
                            rd_cnt  <= '0;
                            wr_cnt  <= '0;
                            state   <= READ;
                        end else begin
                            fd    <= 1'b1;
                            state <= LAST;
                        end
                    end
                end
                READ: begin
                    if (fifo_rxen) begin
                        rd_cnt      <= rd_cnt + 1'b1;
                        wr_cnt      <= wr_cnt + 1'b1;
                        udp_tx_wen  <= 1'b1;
                        udp_tx_addr <= wr_cnt[ADDR_W-1:0];
                    end else if (pad_go) begin
                        wr_cnt      <= wr_cnt + 1'b1;
                        udp_tx_wen  <= 1'b1;
                        pad_wr      <= 1'b1;
                        udp_tx_addr <= wr_cnt[ADDR_W-1:0];
                    end
                    // wr_cnt reaches eff_len exactly while the final write is on the bus.
                    if (udp_tx_wen && (wr_cnt == eff_len)) begin
                        udp_tx_len <= 16'(eff_len) + 16'd8;
                        udp_tx_req <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (udp_tx_done) begin
                        fd    <= 1'b1;
                        state <= LAST;
                    end
                end
                LAST: begin
                    if (!fs) begin
                        fd    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifod2mac.sv
module tb_fifod2mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic [11:0] dev_tx_len;
    logic [7:0]  fifo_rxd;
    logic        fifo_empty;
    logic        fifo_rxen;
    logic [7:0]  udp_txd;
    logic [10:0] udp_tx_addr;
    logic        udp_tx_wen;
    logic [15:0] udp_tx_len;
    logic        udp_tx_req;
    logic        udp_tx_done;

    always #5 clk = ~clk;

`ifdef FIFOD2MAC_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    fifod2mac dut (
        .clk         (clk),
        .rst         (rst),
        .fs          (fs),
        .fd          (fd),
        .dev_tx_len  (dev_tx_len),
        .fifo_rxd    (fifo_rxd),
        .fifo_empty  (fifo_empty),
        .fifo_rxen   (fifo_rxen),
        .udp_txd     (udp_txd),
        .udp_tx_addr (udp_tx_addr),
        .udp_tx_wen  (udp_tx_wen),
        .udp_tx_len  (udp_tx_len),
        .udp_tx_req  (udp_tx_req),
        .udp_tx_done (udp_tx_done)
    );

    // FIFO model: non fall-through, data valid the cycle after a read enable.
    logic [7:0] mem [0:4095];
    int  rptr = 0;
    int  wptr = 0;
    bit  flush = 1'b0;
    int  underflow = 0;

    assign fifo_empty = (rptr == wptr);

    always @(posedge clk) begin
        if (flush) begin
            rptr <= wptr;
        end else if (fifo_rxen) begin
            if (rptr != wptr) begin
                fifo_rxd <= mem[rptr % 4096];
                rptr     <= rptr + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
    end

    // Write / request monitor, sampled 1 time unit after the rising edge.
    logic [10:0] log_addr [0:4095];
    logic [7:0]  log_dat  [0:4095];
    int          nwr = 0;
    int          nreq = 0;
    int          req_long = 0;
    logic [15:0] req_len = '0;
    bit          req_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (udp_tx_wen && nwr < 4096) begin
            log_addr[nwr] = udp_tx_addr;
            log_dat[nwr]  = udp_txd;
            nwr++;
        end
        if (udp_tx_req) begin
            nreq++;
            req_len = udp_tx_len;
            if (req_prev) req_long++;
        end
        req_prev = udp_tx_req;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk($sformatf("%s_fd", tag),          fd,          0);
        chk($sformatf("%s_fifo_rxen", tag),   fifo_rxen,   0);
        chk($sformatf("%s_udp_tx_wen", tag),  udp_tx_wen,  0);
        chk($sformatf("%s_udp_tx_req", tag),  udp_tx_req,  0);
        chk($sformatf("%s_udp_txd", tag),     udp_txd,     0);
        chk($sformatf("%s_udp_tx_addr", tag), udp_tx_addr, 0);
        chk($sformatf("%s_udp_tx_len", tag),  udp_tx_len,  0);
    endtask

    typedef struct {
        int         len;       // dev_tx_len
        int         push_n;    // bytes this frame puts into the FIFO
        int         first;     // bytes available before the stall
        int         stall;     // empty cycles before the rest arrives
        int         exp_rd;    // FIFO bytes the DUT must consume
        int         exp_n;     // buffer writes expected
        int         exp_ulen;  // expected udp_tx_len
        int         exp_req;   // expected number of send requests
        logic [7:0] base;      // first data byte, incrementing
    } vec_t;

    vec_t  vecs  [7];
    string names [7];

    task automatic push_bytes(input logic [7:0] base, input int from, input int to);
        for (int i = from; i < to; i++) begin
            mem[wptr % 4096] = base + 8'(i);
            wptr++;
        end
    endtask

    task automatic run_frame(input int k);
        vec_t v;
        int   r0, w0, q0, pushed, stall_cnt, nw, ae, de, lim;
        bit   got_fd, done_sent;
        logic [7:0] ed;
        v  = vecs[k];
        r0 = rptr;
        w0 = nwr;
        q0 = nreq;
        push_bytes(v.base, 0, v.first);
        pushed    = v.first;
        stall_cnt = 0;
        got_fd    = 1'b0;
        done_sent = 1'b0;
        @(negedge clk);
        fs         = 1'b1;
        dev_tx_len = 12'(v.len);
        for (int cyc = 0; cyc < 5000 && !got_fd; cyc++) begin
            @(negedge clk);
            if (pushed < v.push_n && rptr == wptr) begin
                stall_cnt++;
                if (stall_cnt >= v.stall) begin
                    push_bytes(v.base, pushed, v.push_n);
                    pushed = v.push_n;
                end
            end
            if (!done_sent && nreq > q0) begin
                repeat (3) @(negedge clk);
                chk($sformatf("%s_fd_low_in_wait", names[k]), fd, 0);
                udp_tx_done = 1'b1;
                @(negedge clk);
                udp_tx_done = 1'b0;
                done_sent   = 1'b1;
            end
            if (fd) got_fd = 1'b1;
        end
        chk($sformatf("%s_fd_rise", names[k]), got_fd, 1);
        repeat (3) @(negedge clk);
        chk($sformatf("%s_fd_hold", names[k]), fd, 1);
        fs = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_fd_fall", names[k]), fd, 0);

        nw = nwr - w0;
        chk($sformatf("%s_writes", names[k]), nw, v.exp_n);
        lim = (nw < v.exp_n) ? nw : v.exp_n;
        ae = 0;
        de = 0;
        for (int i = 0; i < lim; i++) begin
            ed = (i < v.exp_rd) ? mem[(r0 + i) % 4096] : 8'h00;
            if (log_addr[w0 + i] != 11'(i)) ae++;
            if (log_dat[w0 + i] != ed) de++;
        end
        chk($sformatf("%s_addr_errs", names[k]), ae, 0);
        chk($sformatf("%s_data_errs", names[k]), de, 0);
        chk($sformatf("%s_reqs", names[k]), nreq - q0, v.exp_req);
        if (v.exp_req != 0)
            chk($sformatf("%s_udp_tx_len", names[k]), req_len, v.exp_ulen);
        chk($sformatf("%s_fifo_consumed", names[k]), rptr - r0, v.exp_rd);

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        //            len   push  first stall rd    n             ulen           req base
        vecs[0] = '{4,    4,    4,    0,    4,    PAD ? 18 : 4, PAD ? 26 : 12, 1, 8'hA0};
        names[0] = "t1_len4";
        vecs[1] = '{6,    6,    2,    5,    6,    PAD ? 18 : 6, PAD ? 26 : 14, 1, 8'h10};
        names[1] = "t2_stall";
        vecs[2] = '{0,    0,    0,    0,    0,    0,            0,             0, 8'h00};
        names[2] = "t3_len0";
        vecs[3] = '{2000, 2000, 2000, 0,    1472, 1472,         1480,          1, 8'h00};
        names[3] = "t4_clamp";
        vecs[4] = '{3,    3,    3,    0,    3,    PAD ? 18 : 3, PAD ? 26 : 11, 1, 8'hC5};
        names[4] = "t6_len3";
        vecs[5] = '{18,   18,   18,   0,    18,   18,           26,            1, 8'h33};
        names[5] = "len18";
        vecs[6] = '{2,    0,    0,    0,    2,    PAD ? 18 : 2, PAD ? 26 : 10, 1, 8'h00};
        names[6] = "t5_after_reset";

        rst         = 1'b1;
        fs          = 1'b0;
        dev_tx_len  = '0;
        udp_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // A stray done while idle must not start or finish anything.
        udp_tx_done = 1'b1;
        @(negedge clk);
        udp_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done_fd", fd, 0);
        chk("idle_done_req", nreq, 0);

        for (int k = 0; k < 6; k++) run_frame(k);

        // Reset in the middle of READ, then a fresh frame must restart at address 0.
        begin
            int w0;
            w0 = nwr;
            push_bytes(8'h50, 0, 10);
            @(negedge clk);
            fs         = 1'b1;
            dev_tx_len = 12'd8;
            for (int c = 0; c < 200 && (nwr - w0) < 3; c++) @(negedge clk);
            chk("t5_three_writes_seen", ((nwr - w0) >= 3) ? 1 : 0, 1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk_zero_outputs("t5_mid_reset");
            fs = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            run_frame(6);
        end

        chk("fifo_underflow", underflow, 0);
        chk("req_single_cycle", req_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
